gift128_endec_core: RTL

Parametrised GIFT-128 engine: one instance performs both encryption and decryption, selected per block, and computes `UNROLL` rounds per clock. It is the successor to the separate one-round-per-cycle encrypt and decrypt cores and uses the same write/busy host interface. It caches the final round-key state, so back-to-back decryptions under one key skip key pre-expansion. It is the cipher primitive for the mode wrappers built above it.

---
 rtl/gift128_endec_core.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/gift128_endec_core.sv
// GIFT-128 encrypt/decrypt engine computing UNROLL rounds per clock.
// Decryption runs the rounds backwards from a cached final key state and round constant.
module gift128_endec_core #(
   parameter int ROUNDS = 40,
   parameter int UNROLL = 1
) (
   input  logic         inClk,
   input  logic         inRst,
   input  logic         inKeyWr,
   input  logic [127:0] inKeyData,
   input  logic         inDataWr,
   input  logic [127:0] inDataData,
   input  logic         inMode,
   output logic [127:0] outData,
   output logic         outValid,
   output logic         outBusy
);
   localparam int N  = ROUNDS / UNROLL;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [63:0] SBOX     = 64'he8057bd2_93f6c4a1;
   localparam logic [63:0] SBOX_INV = 64'h5f93a17e_b4c2680d;

   typedef enum logic [1:0] {IDLE, PREP, RUN_ENC, RUN_DEC} state_t;

   state_t        state_reg;
   logic [127:0]  key_reg, kf_reg, st_reg, wk_reg;
   logic [5:0]    cf_reg, wc_reg;
   logic          cache_valid_reg;
   logic [CW-1:0] ctr_reg;
   logic [127:0]  st_next, wk_next, key_sel;
   logic [5:0]    wc_next;
   logic [127:0]  s_c, k_c;
   logic [5:0]    c_c;
   logic          last_cnt;

   function automatic logic [127:0] sub_cells(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      for (int i = 0; i < 32; i++)
         o[4*i +: 4] = inv ? SBOX_INV[{s[4*i +: 4], 2'b00} +: 4] : SBOX[{s[4*i +: 4], 2'b00} +: 4];
      return o;
   endfunction

   function automatic logic [127:0] perm_bits(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      logic [6:0]   p;
      o = '0;
      for (int i = 0; i < 128; i++) begin
         p = 7'(4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4));
         if (inv) o[i] = s[p];
         else     o[p] = s[i];
      end
      return o;
   endfunction

   // U = k5||k4 goes to bit 4i+2, V = k1||k0 to bit 4i+1.
   function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k,
                                                  input logic [5:0] c);
      logic [127:0] o;
      o = s;
      for (int i = 0; i < 32; i++) begin
         o[4*i+2] = o[4*i+2] ^ k[64+i];
         o[4*i+1] = o[4*i+1] ^ k[i];
      end
      for (int b = 0; b < 6; b++)
         o[4*b+3] = o[4*b+3] ^ c[b];
      o[127] = ~o[127];
      return o;
   endfunction

   function automatic logic [127:0] key_fwd(input logic [127:0] k);
      return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
   endfunction

   function automatic logic [127:0] key_bwd(input logic [127:0] k);
      return {k[95:0], k[125:112], k[127:126], k[99:96], k[111:100]};
   endfunction

   function automatic logic [5:0] lfsr_fwd(input logic [5:0] c);
      return {c[4:0], ~(c[5] ^ c[4])};
   endfunction

   function automatic logic [5:0] lfsr_bwd(input logic [5:0] c);
      return {~(c[0] ^ c[5]), c[5:1]};
   endfunction

   // UNROLL rounds chained combinationally; PREP only advances key and constant.
   always_comb begin
      s_c = st_reg;
      k_c = wk_reg;
      c_c = wc_reg;
      for (int u = 0; u < UNROLL; u++) begin
         if (state_reg == RUN_DEC) begin
            k_c = key_bwd(k_c);
            s_c = sub_cells(perm_bits(add_round_key(s_c, k_c, c_c), 1'b1), 1'b1);
            c_c = lfsr_bwd(c_c);
         end else begin
            c_c = lfsr_fwd(c_c);
            if (state_reg == RUN_ENC)
               s_c = add_round_key(perm_bits(sub_cells(s_c, 1'b0), 1'b0), k_c, c_c);
            k_c = key_fwd(k_c);
         end
      end
      st_next = s_c;
      wk_next = k_c;
      wc_next = c_c;
   end

   assign key_sel  = inKeyWr ? inKeyData : key_reg;
   assign last_cnt = (ctr_reg == CW'(N-1));

   always_ff @(posedge inClk) begin
      if (inRst) begin
         state_reg       <= IDLE;
         key_reg         <= '0;
         kf_reg          <= '0;
         cf_reg          <= '0;
         st_reg          <= '0;
         wk_reg          <= '0;
         wc_reg          <= '0;
         cache_valid_reg <= 1'b0;
         ctr_reg         <= '0;
         outData         <= '0;
         outValid        <= 1'b0;
         outBusy         <= 1'b0;
      end else begin
         outValid <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (inKeyWr) begin
                  key_reg         <= inKeyData;
                  cache_valid_reg <= 1'b0;
               end
               if (inDataWr) begin
                  st_reg  <= inDataData;
                  ctr_reg <= '0;
                  outBusy <= 1'b1;
                  if (!inMode) begin
                     wk_reg    <= key_sel;
                     wc_reg    <= '0;
                     state_reg <= RUN_ENC;
                  end else if (cache_valid_reg && !inKeyWr) begin
                     wk_reg    <= kf_reg;
                     wc_reg    <= cf_reg;
                     state_reg <= RUN_DEC;
                  end else begin
                     wk_reg    <= key_sel;
                     wc_reg    <= '0;
                     state_reg <= PREP;
                  end
               end
            end
            PREP: begin
               wk_reg  <= wk_next;
               wc_reg  <= wc_next;
               ctr_reg <= last_cnt ? '0 : ctr_reg + 1'b1;
               if (last_cnt) begin
                  kf_reg          <= wk_next;
                  cf_reg          <= wc_next;
                  cache_valid_reg <= 1'b1;
                  state_reg       <= RUN_DEC;
               end
            end
            RUN_ENC, RUN_DEC: begin
               st_reg  <= st_next;
               wk_reg  <= wk_next;
               wc_reg  <= wc_next;
               ctr_reg <= last_cnt ? '0 : ctr_reg + 1'b1;
               if (last_cnt) begin
                  outData   <= st_next;
                  outValid  <= 1'b1;
                  outBusy   <= 1'b0;
                  state_reg <= IDLE;
                  if (state_reg == RUN_ENC) begin
                     kf_reg          <= wk_next;
                     cf_reg          <= wc_next;
                     cache_valid_reg <= 1'b1;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule
